// File: rtl/uart_tx_if.sv
// uart_tx_if -- core-side handshake and serial outputs of the UART transmitter.
//   tx_start : one-cycle send request from the core
//   tx_data  : byte to send, sampled only when a request is accepted
//   tx       : serial line, idle high
//   t_byte_o : busy/stall request to the hazard unit
//   tx_done  : one-cycle frame-complete pulse
// master = core side, slave = transmitter side.
interface uart_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       t_byte_o;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  t_byte_o,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output t_byte_o,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with registered outputs.
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : uart_tx_if.slave (tx_start, tx_data in; tx, t_byte_o, tx_done out)
// Frame: start bit 0, eight data bits LSB first, stop bit 1; every bit lasts
// CLKS_PER_BIT cycles. Requests are accepted only in IDLE; the cycle after a
// frame is always IDLE, giving at least one idle-high cycle between frames.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input logic   clk,
    input logic   rst,
    uart_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            bus.tx       <= 1'b1;
            bus.t_byte_o <= 1'b0;
            bus.tx_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.tx_done <= 1'b0;
                    baud_cnt    <= '0;
                    bit_idx     <= '0;
                    if (bus.tx_start) begin
                        shreg        <= bus.tx_data;
                        state        <= START;
                        bus.tx       <= 1'b0;
                        bus.t_byte_o <= 1'b1;
                    end else begin
                        bus.tx       <= 1'b1;
                        bus.t_byte_o <= 1'b0;
                    end
                end

                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        bus.tx   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            bus.tx  <= 1'b1;
                        end else begin
                            // shreg[0] is the bit on the line; shift so the
                            // next bit moves into position 0.
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            bus.tx  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP: begin
                    // Requests arriving here are dropped; the return to IDLE
                    // makes the next request wait at least one idle cycle.
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt     <= '0;
                        state        <= IDLE;
                        bus.tx       <= 1'b1;
                        bus.t_byte_o <= 1'b0;
                        bus.tx_done  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.tx       <= 1'b1;
                    bus.t_byte_o <= 1'b0;
                    bus.tx_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
